// File: rtl/wb_trace_pkg.sv
// Shared types for the write-back trace path.
// Holds the architectural widths and the trace entry layout.
// SEQ_W here is the widest sequence number an entry can carry.
package wb_trace_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;
  localparam int SEQ_W = 16;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous DEPTH-entry FIFO of a packed entry type, count tracks occupancy.
// Latency: a push is visible at dout on the cycle after the write edge when empty.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = trace_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 din,
  output entry_t                 dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Occupancy next state from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/wb_trace_collector.sv
// Turns the CPU write-back stream into a sequence-numbered trace FIFO plus a shadow register file.
// Latency: a qualifying write in cycle N is at the FIFO head in cycle N+1 when the FIFO was empty.
// Backpressure: trace_ready stalls the head; events arriving while full without a pop are dropped and counted.
module wb_trace_collector
  import wb_trace_pkg::trace_entry_t;
  import wb_trace_pkg::REG_W;
  import wb_trace_pkg::XLEN;
#(
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RegWriteW,
  input  logic [REG_W-1:0]       RdW,
  input  logic [XLEN-1:0]        ResultW,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [REG_W-1:0]       trace_rd,
  output logic [XLEN-1:0]        trace_data,
  output logic [SEQ_W-1:0]       trace_seq,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  input  logic                   clear_overflow,
  input  logic [REG_W-1:0]       dbg_addr,
  output logic [XLEN-1:0]        dbg_data
);

  // Entry seq field width; SEQ_W must not exceed it.
  localparam int ESEQ_W = wb_trace_pkg::SEQ_W;

  logic               qual, pop, drop;
  logic               fifo_full, fifo_empty;
  trace_entry_t       push_entry, head;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [XLEN-1:0]    shadow_q [1:31];
  logic [ESEQ_W-1:0]  unused_head_seq;

  // Writes to x0 are invisible to everything downstream.
  assign qual = RegWriteW && (RdW != '0);
  assign pop  = trace_valid && trace_ready;
  assign drop = qual && fifo_full && !pop;

  // Build the entry for the current event.
  always_comb begin
    push_entry      = '0;
    push_entry.seq  = ESEQ_W'(seq_q);
    push_entry.rd   = RdW;
    push_entry.data = ResultW;
  end

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (trace_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (qual),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign trace_valid     = !fifo_empty;
  assign trace_rd        = head.rd;
  assign trace_data      = head.data;
  assign trace_seq       = head.seq[SEQ_W-1:0];
  assign unused_head_seq = head.seq;

  // Every qualifying event takes a sequence number, dropped or not.
  always_comb begin
    seq_d = seq_q;
    if (qual) seq_d = seq_q + SEQ_W'(1);
  end

  // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear.
  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_overflow)   drop_d = DROP_W'(1);
      else if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end
  end

  // Sequence, overflow and drop state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_q;

  // Shadow register file follows every qualifying write, independent of FIFO space.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) shadow_q[i] <= '0;
    end else if (qual) begin
      shadow_q[RdW] <= ResultW;
    end
  end

  // Read port sees the pre-write value during the write cycle.
  assign dbg_data = (dbg_addr == '0) ? '0 : shadow_q[dbg_addr];

endmodule

// File: doc/wb_trace_collector.md
# wb_trace_collector

Receives the CPU's write-back retirement stream (RegWriteW, RdW, ResultW) and turns it into a sequence-numbered trace for the bench and debug logic. It sits beside the CPU top and is the consuming end of that stream. Each qualifying register write goes into a FIFO, which drains over a valid/ready port. A shadow copy of the architectural register file is kept in step with the same writes and can be read back through a debug port.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- SEQ_W, 16, sequence-number width
- DROP_W, 16, dropped-event counter width

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (asserted at 0)
- RegWriteW  in  1  write-back enable from CPU
- RdW  in  5  write-back destination register
- ResultW  in  32  write-back data
- trace_valid  out  1  head entry available
- trace_ready  in  1  consumer accepts head entry
- trace_rd  out  5  head entry destination
- trace_data  out  32  head entry data
- trace_seq  out  SEQ_W  head entry sequence number
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky: an event was dropped
- drop_count  out  DROP_W  number of dropped events, saturating
- clear_overflow  in  1  synchronous clear of overflow and drop_count
- dbg_addr  in  5  shadow register index
- dbg_data  out  32  shadow register value (combinational)

## Operation
- An event qualifies when RegWriteW=1 and RdW≠0. Writes to x0 are ignored entirely: no push, no sequence increment, no shadow update.
- On each qualifying event:
  - shadow[RdW] ← ResultW.
  - The entry {seq, RdW, ResultW} is pushed if there is space.
  - seq increments by one, wrapping modulo 2^SEQ_W. Dropped events also consume a sequence number, so the consumer sees a gap.
- Push is accepted when fifo_count<DEPTH, or when fifo_count=DEPTH and a pop occurs in the same cycle. In the full-with-pop case, occupancy stays at DEPTH.
- Drop handling:
  - A drop happens when the FIFO is full and there is no pop.
  - A drop sets overflow and increments drop_count, which saturates at 2^DROP_W−1.
- A pop happens when trace_valid && trace_ready.
- trace_valid = (fifo_count≠0). The trace_rd, trace_data and trace_seq outputs present the head entry.
- The head entry must hold stable while trace_valid && !trace_ready.
- clear_overflow:
  - Zeroes overflow and drop_count on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_count=1.
- dbg_data = shadow[dbg_addr]. It returns 0 for dbg_addr=0.
- When the same register is written and read in the same cycle, dbg_data shows the old value; the new value is visible from the next cycle.

## Timing
- Reset (reset=0, asynchronous) clears the following. All outputs read 0 during reset and after release.
  - FIFO pointers, so fifo_count=0 and trace_valid=0.
  - seq=0, overflow=0, drop_count=0.
  - All shadow registers.
- Latency:
  - A qualifying event in cycle N is captured at the edge ending N.
  - trace_valid is asserted in cycle N+1, provided the FIFO was empty.
  - There is no combinational path from RegWriteW to trace_valid.
- Throughput: one push and one pop per cycle, sustained indefinitely at full bandwidth.
- Pointers wrap modulo DEPTH. fifo_count distinguishes full from empty.
- Reset asserted mid-stream discards all FIFO contents immediately. The consumer must not rely on any handshake completing in that cycle.
- There is no combinational path from trace_ready to any output other than through registered state.

## Structure
- Package wb_trace_pkg holds:
  - localparams REG_W=5 and XLEN=32.
  - trace_entry_t packed struct {seq, rd, data}, parameterized via SEQ_W from the package.
- Sub-module trace_fifo is a synchronous DEPTH×trace_entry_t FIFO.
  - Ports: push, pop, din, dout, count, full, empty; async active-low reset.
  - Reused later for other debug streams.
- Top-level wb_trace_collector holds:
  - Qualification logic.
  - Sequence counter.
  - Overflow and drop counter logic.
  - The 31×32 shadow register array.

## Test plan
- **Reset release.** Reset=0 for 3 cycles, then 1 → all outputs 0 and trace_valid=0. dbg_data=0 for every dbg_addr.
- **Single write.** RegWriteW=1, RdW=5, ResultW=0xDEADBEEF, trace_ready=0 → next cycle trace_valid=1, trace_rd=5, trace_data=0xDEADBEEF, trace_seq=0; dbg_addr=5 reads 0xDEADBEEF. Holding ready=0 for 10 cycles keeps the fields stable. Ready=1 pops and fifo_count returns to 0.
- **x0 filter.** RegWriteW=1, RdW=0, ResultW=0x1234 → no push, seq unchanged. The next write to x3 carries trace_seq=0.
- **Overflow.** trace_ready=0 and 11 writes with DEPTH=8 → fifo_count=8, overflow=1, drop_count=3. Draining yields seq 0..7. The next write carries seq=11. clear_overflow → overflow=0, drop_count=0.
- **Full with simultaneous push and pop.** FIFO full, trace_ready=1 and a write in the same cycle → no drop, fifo_count stays 8, and the new entry appears last in order.
- **Wrap.** SEQ_W=4 build, 20 back-to-back writes with ready=1 → seq runs 0..15,0..3 and the FIFO pointers wrap without loss. Asserting reset mid-burst gives trace_valid=0 immediately.
